// File: rtl/shot_sched_pkg.sv
// Shared types and helpers for the shot scheduler: state encoding, round-robin pick, one-hot.
package shot_sched_pkg;

   localparam int unsigned MAX_N  = 32;
   localparam int unsigned MAX_IW = $clog2(MAX_N);

   typedef logic [0:0] state_t;
   localparam state_t IDLE = 1'b0;
   localparam state_t BUSY = 1'b1;

   // First set bit of elig scanning ptr, ptr+1, ... mod n; returns ptr when nothing is set.
   function automatic int unsigned rr_pick(input logic [MAX_N-1:0] elig,
                                           input int unsigned ptr,
                                           input int unsigned n);
      int unsigned idx;
      logic        found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         if (i < n && !found) begin
            idx = (ptr + i) % n;
            if (elig[idx[MAX_IW-1:0]]) begin
               found   = 1'b1;
               rr_pick = idx;
            end
         end
      end
   endfunction

   function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
      onehot = '0;
      onehot[idx[MAX_IW-1:0]] = 1'b1;
   endfunction

endpackage

// File: rtl/shot_sched_upctr.sv
// Free-running up-counter that wraps to zero after reaching terminal count L.
module shot_sched_upctr #(
   parameter int unsigned W = 16,
   parameter int unsigned L = 49999
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc) begin
         cnt_d = (cnt_q == W'(L)) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/shot_sched.sv
// Round-robin scheduler for one shared shot engine with per-requester tick-based cooldown.
// Optional busy watchdog enabled by defining SHOT_SCHED_TIMEOUT_EN.
module shot_sched
   import shot_sched_pkg::*;
#(
   parameter int unsigned N         = 4,
   parameter int unsigned TICK_W    = 16,
   parameter int unsigned TICK_L    = 49999,
   parameter int unsigned CD_W      = 8,
   parameter int unsigned CD_TICKS  = 100,
   parameter int unsigned TO_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic                 done,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 start,
   output logic                 busy,
   output logic [N-1:0]         ready,
   output logic                 timeout
);

   localparam int unsigned IW = $clog2(N);

   if (CD_TICKS > (2 ** CD_W) - 1) begin : g_cd_chk
      $error("CD_TICKS does not fit in CD_W bits");
   end
   if (TO_CYCLES < 1) begin : g_to_chk
      $error("TO_CYCLES must be at least 1");
   end
   if (N < 2 || N > MAX_N) begin : g_n_chk
      $error("N out of range");
   end

   logic [TICK_W-1:0] pre_cnt;
   logic              tick;

   shot_sched_upctr #(
      .W (TICK_W),
      .L (TICK_L)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .inc   (1'b1),
      .cnt   (pre_cnt)
   );

   assign tick = (pre_cnt == TICK_W'(TICK_L));

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CD_W-1:0] cd_q [N];
   logic [CD_W-1:0] cd_d [N];
   logic [N-1:0]    gnt_q, gnt_d;
   logic [IW-1:0]   gnt_id_q, gnt_id_d;
   logic            start_q, start_d;
   logic            timeout_q, timeout_d;
   logic [N-1:0]    elig;
   logic [IW-1:0]   sel;
   logic            grant;
   logic            expire;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         ready[i] = (cd_q[i] == '0);
      end
   end

   assign elig  = req & ready;
   assign sel   = IW'(rr_pick(MAX_N'(elig), 32'(rr_ptr_q), N));
   assign grant = (state_q == IDLE) && (elig != '0);

`ifdef SHOT_SCHED_TIMEOUT_EN
   localparam int unsigned TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   // done in the expiry cycle takes priority over the watchdog
   assign expire = (state_q == BUSY) && !done && (to_cnt_q == TO_W'(TO_CYCLES - 1));

   always_comb begin
      to_cnt_d = to_cnt_q;
      if (grant) begin
         to_cnt_d = '0;
      end else if (state_q == BUSY) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_d     = '0;
      gnt_id_d  = '0;
      start_d   = 1'b0;
      timeout_d = 1'b0;
      if (grant) begin
         state_d  = BUSY;
         rr_ptr_d = (sel == IW'(N - 1)) ? '0 : sel + 1'b1;
         gnt_d    = N'(onehot(32'(sel)));
         gnt_id_d = sel;
         start_d  = 1'b1;
      end else if (state_q == BUSY && (done || expire)) begin
         state_d   = IDLE;
         timeout_d = expire;
      end
   end

   // Grant load wins over a same-cycle tick decrement
   always_comb begin
      for (int i = 0; i < N; i++) begin
         cd_d[i] = cd_q[i];
         if (tick && cd_q[i] != '0) begin
            cd_d[i] = cd_q[i] - 1'b1;
         end
         if (grant && sel == IW'(i)) begin
            cd_d[i] = CD_W'(CD_TICKS);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         start_q   <= 1'b0;
         timeout_q <= 1'b0;
         for (int i = 0; i < N; i++) begin
            cd_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         start_q   <= start_d;
         timeout_q <= timeout_d;
         for (int i = 0; i < N; i++) begin
            cd_q[i] <= cd_d[i];
         end
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign start   = start_q;
   assign busy    = (state_q == BUSY);
   assign timeout = timeout_q;

endmodule

// File: tb/tb_shot_sched.sv
// Directed bench for shot_sched: cycle table plus hand sequences for cooldown, reset and watchdog.
module tb_shot_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       start;
   logic       busy;
   logic [3:0] ready;
   logic       timeout;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   shot_sched #(
      .N         (4),
      .TICK_W    (4),
      .TICK_L    (3),
      .CD_W      (4),
      .CD_TICKS  (2),
      .TO_CYCLES (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .start   (start),
      .busy    (busy),
      .ready   (ready),
      .timeout (timeout)
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       done;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       start;
      logic       busy;
      logic [3:0] ready;
   } vec_t;

   vec_t vecs [22];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      done  = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic setv(input int i, input logic r, input logic [3:0] q, input logic d,
                       input logic [3:0] g, input logic [1:0] id, input logic s,
                       input logic b, input logic [3:0] rd);
      vecs[i] = '{rst: r, req: q, done: d, gnt: g, id: id, start: s, busy: b, ready: rd};
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      done  = 1'b0;

      // Each row: inputs for one cycle, outputs expected after the following edge.
      // Prescaler ticks in rows 4, 8, 12, 16, 20.
      setv( 0, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'b1111);
      setv( 1, 0, 4'b0001, 0, 4'b0001, 0, 1, 1, 4'b1110);
      setv( 2, 0, 4'b0000, 0, 4'b0000, 0, 0, 1, 4'b1110);
      setv( 3, 0, 4'b0000, 0, 4'b0000, 0, 0, 1, 4'b1110);
      setv( 4, 0, 4'b0000, 0, 4'b0000, 0, 0, 1, 4'b1110);
      setv( 5, 0, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b1110);
      setv( 6, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'b1110);
      setv( 7, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'b1110);
      setv( 8, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'b1111);
      setv( 9, 0, 4'b0001, 1, 4'b0001, 0, 1, 1, 4'b1110);
      setv(10, 0, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b1110);
      setv(11, 0, 4'b0010, 0, 4'b0010, 1, 1, 1, 4'b1100);
      setv(12, 0, 4'b1111, 1, 4'b0000, 0, 0, 0, 4'b1100);
      setv(13, 0, 4'b1111, 0, 4'b0100, 2, 1, 1, 4'b1000);
      setv(14, 0, 4'b1111, 1, 4'b0000, 0, 0, 0, 4'b1000);
      setv(15, 0, 4'b1111, 0, 4'b1000, 3, 1, 1, 4'b0000);
      setv(16, 0, 4'b1111, 1, 4'b0000, 0, 0, 0, 4'b0011);
      setv(17, 0, 4'b1111, 0, 4'b0001, 0, 1, 1, 4'b0010);
      setv(18, 0, 4'b1111, 1, 4'b0000, 0, 0, 0, 4'b0010);
      setv(19, 0, 4'b1111, 0, 4'b0010, 1, 1, 1, 4'b0000);
      setv(20, 0, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b1100);
      setv(21, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'b1100);

      #1;
      for (int i = 0; i < 22; i++) begin
         reset = vecs[i].rst;
         req   = vecs[i].req;
         done  = vecs[i].done;
         step();
         check($sformatf("row%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
         check($sformatf("row%0d start", i), 32'(start), 32'(vecs[i].start));
         check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].busy));
         check($sformatf("row%0d ready", i), 32'(ready), 32'(vecs[i].ready));
         check($sformatf("row%0d timeout", i), 32'(timeout), 32'd0);
         if (vecs[i].start) begin
            check($sformatf("row%0d gnt_id", i), 32'(gnt_id), 32'(vecs[i].id));
         end
      end

      // Cooldown on requester 2 with its request held throughout.
      do_reset();
      req = 4'b0100;
      step();
      check("cd grant", 32'(gnt), 32'b0100);
      check("cd grant id", 32'(gnt_id), 32'd2);
      done = 1'b1;
      step();
      done = 1'b0;
      for (int k = 3; k <= 9; k++) begin
         step();
         check($sformatf("cd k%0d gnt", k), 32'(gnt), (k == 9) ? 32'b0100 : 32'd0);
         if (k <= 8) begin
            check($sformatf("cd k%0d ready2", k), 32'(ready[2]), (k == 8) ? 32'd1 : 32'd0);
         end
      end
      req = '0;
      done = 1'b1;
      step();
      done = 1'b0;

      // Reset in the middle of BUSY.
      do_reset();
      req = 4'b1111;
      step();
      check("rst grant0", 32'(gnt), 32'b0001);
      req = '0;
      step();
      check("rst busy before", 32'(busy), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst busy", 32'(busy), 32'd0);
      check("rst ready", 32'(ready), 32'b1111);
      check("rst start", 32'(start), 32'd0);
      req = 4'b1000;
      step();
      check("rst regrant gnt", 32'(gnt), 32'b1000);
      check("rst regrant id", 32'(gnt_id), 32'd3);
      req = '0;
      done = 1'b1;
      step();
      done = 1'b0;
      // Pointer is back at 0 after reset, so 1001 picks requester 0.
      do_reset();
      req = 4'b1001;
      step();
      check("rst ptr gnt", 32'(gnt), 32'b0001);
      req = '0;
      done = 1'b1;
      step();
      done = 1'b0;

      // Busy watchdog.
      do_reset();
      req = 4'b0001;
      step();
      check("wd start", 32'(start), 32'd1);
      req = '0;
`ifdef SHOT_SCHED_TIMEOUT_EN
      for (int k = 1; k <= 10; k++) begin
         step();
         check($sformatf("wd k%0d timeout", k), 32'(timeout), (k == 8) ? 32'd1 : 32'd0);
         check($sformatf("wd k%0d busy", k), 32'(busy), (k < 8) ? 32'd1 : 32'd0);
      end
      req = 4'b0010;
      step();
      check("wd2 start", 32'(start), 32'd1);
      req = '0;
      for (int k = 1; k <= 9; k++) begin
         done = (k == 8);
         step();
         check($sformatf("wd2 k%0d timeout", k), 32'(timeout), 32'd0);
         check($sformatf("wd2 k%0d busy", k), 32'(busy), (k < 8) ? 32'd1 : 32'd0);
      end
      done = 1'b0;
`else
      for (int k = 1; k <= 12; k++) begin
         step();
         check($sformatf("nowd k%0d timeout", k), 32'(timeout), 32'd0);
         check($sformatf("nowd k%0d busy", k), 32'(busy), 32'd1);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      check("nowd release", 32'(busy), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
